fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register with branch/jump/trap redirect and the IF/ID
// pipeline register, including flush on redirect and a count of delivered instructions.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              IMEM_AW  = 6,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100),
  parameter logic [XLEN-1:0] NOP      = '0
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               stall,
  input  logic [1:0]         pcsource,
  input  logic [XLEN-1:0]    bpc,
  input  logic [XLEN-1:0]    jpc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_data,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc4,
  output logic [XLEN-1:0]    id_inst,
  output logic [XLEN-1:0]    id_pc,
  output logic [XLEN-1:0]    id_pc4,
  output logic               id_valid,
  output logic               misalign_err,
  output logic [31:0]        fetch_cnt
);

  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] pc4_p0;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            misalign;

  logic [XLEN-1:0] inst_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] pc4_p1;
  logic            vld_p1;
  logic            mis_p1;
  logic [31:0]     cnt_p1;

  assign pc4_p0    = pc_p0 + STEP;
  assign imem_addr = pc_p0[IMEM_AW+1:2];

  // Next-PC selection; a redirect outranks stall, and a misaligned target traps.
  always_comb begin
    redirect = (pcsource != 2'b00);
    misalign = 1'b0;
    next_pc  = TRAP_VEC;
    case (pcsource)
      2'b00:   next_pc = stall ? pc_p0 : pc4_p0;
      2'b01:   next_pc = bpc;
      2'b10:   next_pc = jpc;
      default: next_pc = TRAP_VEC;
    endcase
    if ((pcsource == 2'b01 || pcsource == 2'b10) && next_pc[1:0] != 2'b00) begin
      misalign = 1'b1;
      next_pc  = TRAP_VEC;
    end
  end

  // Stage p0: program counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_p0 <= RESET_PC;
    end else begin
      pc_p0 <= next_pc;
    end
  end

  // Stage p1: IF/ID register; a redirect squashes the wrong-path fetch.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inst_p1 <= NOP;
      pc_p1   <= RESET_PC;
      pc4_p1  <= RESET_PC + STEP;
      vld_p1  <= 1'b0;
      mis_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      mis_p1 <= misalign;
      if (redirect) begin
        inst_p1 <= NOP;
        pc_p1   <= pc_p0;
        pc4_p1  <= pc4_p0;
        vld_p1  <= 1'b0;
      end else if (!stall) begin
        inst_p1 <= imem_data;
        pc_p1   <= pc_p0;
        pc4_p1  <= pc4_p0;
        vld_p1  <= 1'b1;
        cnt_p1  <= cnt_p1 + 32'd1;
      end
    end
  end

  assign pc           = pc_p0;
  assign pc4          = pc4_p0;
  assign id_inst      = inst_p1;
  assign id_pc        = pc_p1;
  assign id_pc4       = pc4_p1;
  assign id_valid     = vld_p1;
  assign misalign_err = mis_p1;
  assign fetch_cnt    = cnt_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural fetch model checked every falling edge,
// plus hand-computed literal expectations at key points of the directed sequence.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] TRAP   = 32'h100;
  localparam logic [31:0] NOPW   = 32'h0;

  logic        clk, clrn, stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data, pc, pc4, id_inst, id_pc, id_pc4, fetch_cnt;
  logic        id_valid, misalign_err;

  logic [31:0] rom [64];
  assign imem_data = rom[imem_addr];

  fetch_unit dut (
    .clk(clk), .clrn(clrn), .stall(stall), .pcsource(pcsource),
    .bpc(bpc), .jpc(jpc), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .pc4(pc4), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_valid(id_valid), .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: next PC and IF/ID contents from the fetch rules directly.
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4, m_cnt, m_tgt;
  logic        m_valid, m_mis, m_bad;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_pc = RST_PC; m_inst = NOPW; m_ipc = RST_PC; m_ipc4 = RST_PC + 4;
      m_valid = 1'b0; m_mis = 1'b0; m_cnt = 0;
    end else begin
      m_bad = 1'b0;
      if (pcsource == 2'd0)      m_tgt = stall ? m_pc : m_pc + 4;
      else if (pcsource == 2'd1) begin m_tgt = bpc; m_bad = (bpc % 4) != 0; end
      else if (pcsource == 2'd2) begin m_tgt = jpc; m_bad = (jpc % 4) != 0; end
      else                       m_tgt = TRAP;
      if (m_bad) m_tgt = TRAP;
      if (pcsource != 2'd0) begin
        m_inst = NOPW; m_valid = 1'b0; m_ipc = m_pc; m_ipc4 = m_pc + 4;
      end else if (!stall) begin
        m_inst = rom[(m_pc / 4) % 64]; m_valid = 1'b1;
        m_ipc = m_pc; m_ipc4 = m_pc + 4; m_cnt = m_cnt + 1;
      end
      m_mis = m_bad;
      m_pc  = m_tgt;
    end
  end

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc + 4);
    chk("imem_addr", {26'd0, imem_addr}, (m_pc / 4) % 64);
    chk("id_inst", id_inst, m_inst);
    chk("id_pc", id_pc, m_ipc);
    chk("id_pc4", id_pc4, m_ipc4);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    chk("fetch_cnt", fetch_cnt, m_cnt);
  end

  task automatic cyc(input logic st, input logic [1:0] ps, input logic [31:0] b, input logic [31:0] j);
    stall = st; pcsource = ps; bpc = b; jpc = j;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) rom[k] = k + 1;
    stall = 1'b0; pcsource = 2'b00; bpc = '0; jpc = '0;
    clrn = 1'b1;
    #1 clrn = 1'b0;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_id_pc4", id_pc4, 32'h4);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 clrn = 1'b1;

    // sequential fetch
    cyc(0, 2'b00, 0, 0);
    chk("seq_pc1", pc, 32'h4);
    chk("seq_inst1", id_inst, 32'd1);
    cyc(0, 2'b00, 0, 0);
    chk("seq_pc2", pc, 32'h8);
    chk("seq_inst2", id_inst, 32'd2);
    // stall holds
    cyc(1, 2'b00, 0, 0);
    cyc(1, 2'b00, 0, 0);
    chk("stall_pc", pc, 32'h8);
    chk("stall_cnt", fetch_cnt, 32'd2);
    cyc(0, 2'b00, 0, 0);
    chk("resume_pc", pc, 32'hC);
    chk("resume_inst", id_inst, 32'd3);
    chk("resume_cnt", fetch_cnt, 32'd3);
    // branch with stall: redirect wins
    cyc(1, 2'b01, 32'h40, 0);
    chk("br_pc", pc, 32'h40);
    chk("br_inst", id_inst, NOPW);
    chk("br_valid", {31'd0, id_valid}, 32'd0);
    chk("br_cnt", fetch_cnt, 32'd3);
    chk("br_id_pc", id_pc, 32'hC);
    cyc(0, 2'b00, 0, 0);
    chk("post_br_inst", id_inst, 32'd17);
    // misaligned jump -> trap
    cyc(0, 2'b10, 0, 32'h42);
    chk("mj_pc", pc, TRAP);
    chk("mj_err", {31'd0, misalign_err}, 32'd1);
    cyc(0, 2'b00, 0, 0);
    chk("mj_err_clr", {31'd0, misalign_err}, 32'd0);
    chk("mj_pc2", pc, 32'h104);
    // explicit trap, then address wrap at 0xFC -> 0x100
    cyc(0, 2'b11, 0, 0);
    chk("trap_pc", pc, TRAP);
    cyc(0, 2'b10, 0, 32'hFC);
    chk("wrap_addr63", {26'd0, imem_addr}, 32'd63);
    cyc(0, 2'b00, 0, 0);
    chk("wrap_addr0", {26'd0, imem_addr}, 32'd0);
    chk("wrap_inst", id_inst, 32'd64);
    // misaligned branch, stalled
    cyc(1, 2'b01, 32'h41, 0);
    chk("mb_pc", pc, TRAP);
    chk("mb_err", {31'd0, misalign_err}, 32'd1);
    // pc4 wraps at top of address space
    cyc(0, 2'b10, 0, 32'hFFFF_FFFC);
    chk("top_pc4", pc4, 32'h0);
    cyc(0, 2'b00, 0, 0);
    chk("top_wrap_pc", pc, 32'h0);
    // mixed pattern
    cyc(1, 2'b00, 0, 0);
    cyc(0, 2'b00, 0, 0);
    cyc(1, 2'b10, 0, 32'h1C);
    cyc(0, 2'b00, 0, 0);
    chk("pre_rst_pc", pc, 32'h20);
    // asynchronous reset pulse between edges
    #1 clrn = 1'b0;
    #1;
    chk("arst_pc", pc, RST_PC);
    chk("arst_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_cnt", fetch_cnt, 32'd0);
    clrn = 1'b1;
    cyc(0, 2'b00, 0, 0);
    chk("after_rst_pc", pc, 32'h4);
    chk("after_rst_inst", id_inst, 32'd1);
    cyc(1, 2'b11, 0, 0);
    cyc(0, 2'b00, 0, 0);
    cyc(0, 2'b00, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
